// File: rtl/dcp_dark_channel_win.sv
// Dark/bright channel extractor: per-pixel min/max over colour components followed by
// a causal WIN-pixel horizontal min/max window along the current line. Fixed 3-cycle latency.
module dcp_dark_channel_win #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int WIN      = 3
) (
    input  logic                         pixelclk,
    input  logic                         reset_n,
    input  logic                         i_mode,
    input  logic [CHANNELS*DATA_W-1:0]   i_pix,
    input  logic                         i_data_valid,
    input  logic                         i_line_start,
    output logic [DATA_W-1:0]            o_dark,
    output logic                         o_data_valid,
    output logic                         o_line_start
);

    logic              mode_lat;
    logic              eff_mode;
    logic [DATA_W-1:0] pix_red;
    logic [DATA_W-1:0] comp;

    logic              s1_val;
    logic              s1_ls;
    logic              s1_mode;
    logic [DATA_W-1:0] s1_data;

    logic              s2_val;
    logic              s2_ls;
    logic              s2_mode;
    logic [DATA_W-1:0] win_val [WIN];
    logic [WIN-1:0]    win_occ;
    logic [DATA_W-1:0] win_red;

    // A line-start pixel uses its own i_mode; every other pixel follows the latched line mode.
    assign eff_mode = (i_data_valid && i_line_start) ? i_mode : mode_lat;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pix_red = i_pix[DATA_W-1:0];
        comp    = '0;
        for (int k = 1; k < CHANNELS; k++) begin
            comp = i_pix[k*DATA_W +: DATA_W];
            if (eff_mode ? (comp > pix_red) : (comp < pix_red))
                pix_red = comp;
        end
    end

    // Unoccupied slots start from the identity value so they never win the compare.
    always_comb begin
        win_red = s2_mode ? '0 : '1;
        for (int i = 0; i < WIN; i++) begin
            if (win_occ[i] && (s2_mode ? (win_val[i] > win_red) : (win_val[i] < win_red)))
                win_red = win_val[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all stages update together.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            mode_lat <= 1'b0;
            s1_val   <= 1'b0;
            s1_ls    <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (i_data_valid && i_line_start)
                mode_lat <= i_mode;
            s1_val  <= i_data_valid;
            s1_ls   <= i_data_valid & i_line_start;
            s1_mode <= eff_mode;
            s1_data <= i_data_valid ? pix_red : '0;
        end
    end

    // NOTE: the window is a handful of registers, not a RAM, so it is cleared by reset
    // to guarantee no pre-reset pixel can leak into the first line.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            s2_val  <= 1'b0;
            s2_ls   <= 1'b0;
            s2_mode <= 1'b0;
            win_occ <= '0;
            for (int i = 0; i < WIN; i++)
                win_val[i] <= '0;
        end else begin
            s2_val  <= s1_val;
            s2_ls   <= s1_ls;
            if (s1_val) begin
                s2_mode    <= s1_mode;
                win_val[0] <= s1_data;
                win_occ[0] <= 1'b1;
                for (int i = 1; i < WIN; i++) begin
                    win_val[i] <= win_val[i-1];
                    win_occ[i] <= win_occ[i-1] & ~s1_ls;
                end
            end
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_dark       <= '0;
            o_data_valid <= 1'b0;
            o_line_start <= 1'b0;
        end else begin
            o_dark       <= s2_val ? win_red : '0;
            o_data_valid <= s2_val;
            o_line_start <= s2_val & s2_ls;
        end
    end

endmodule

// File: doc/dcp_dark_channel_win.md
Name: dcp_dark_channel_win

Overview:
Parametrised dark/bright channel extractor for the DCP dehaze pipeline. Each cycle it reduces CHANNELS colour components to a single value, using min (dark channel) or max (bright channel). It then applies a causal horizontal sliding-window reduction of WIN pixels along the current line. Output is a fixed-latency stream with valid and line-start markers aligned to it, ready for the transmission-estimate stage.

Parameters:
DATA_W, 8, bit width of one colour component and of the output
CHANNELS, 3, number of components packed in i_pix (legal 1..8)
WIN, 3, horizontal window length in pixels (legal 1..15; 1 = per-pixel only)

Ports:
pixelclk  input  1  pixel clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
i_mode  input  1  0 = min (dark channel), 1 = max (bright channel)
i_pix  input  CHANNELS*DATA_W  packed components; component k at [k*DATA_W +: DATA_W]; k=CHANNELS-1 is R for RGB
i_data_valid  input  1  i_pix valid this cycle
i_line_start  input  1  first pixel of a line; meaningful only when i_data_valid=1
o_dark  output  DATA_W  window-reduced result
o_data_valid  output  1  o_dark valid
o_line_start  output  1  line-start marker aligned to o_dark

Behaviour:
- Reset: async assert clears all pipeline registers, window contents, slot-occupied flags and the latched mode. o_dark=0, o_data_valid=0, o_line_start=0. Latched mode resets to 0 (min).
- Mode latch: i_mode is sampled only on a cycle with i_data_valid=1 and i_line_start=1. The latched mode governs that whole line. i_mode changes mid-line have no effect until the next line start.
- Stage 1 (reg): for each valid pixel, reduce all CHANNELS components with min or max, per the mode effective for that pixel. Mode at stage 1 = i_mode if the pixel is a line start, else the latched mode. The valid, line-start and mode flags are pipelined alongside the data.
- Stage 2 (reg): window shift register of WIN entries, each holding a value plus an occupied flag. It shifts only when the stage-1 valid is set.
  - On a stage-1 line-start pixel, every older slot is cleared to unoccupied and the new pixel enters occupied.
  - Gaps in valid do not advance the window: the window spans the last WIN valid pixels of the current line.
- Stage 3 (reg): reduce the occupied slots, using min or max per the pipelined mode. Unoccupied slots contribute the identity value: all-ones for min, 0 for max. The newest slot is always occupied on a valid cycle.
- Latency: exactly 3 pixelclk cycles from i_data_valid to o_data_valid, independent of WIN and CHANNELS. o_line_start follows the same delay.
- o_dark is 0 whenever o_data_valid=0. o_line_start is 0 whenever o_data_valid=0.
- Window alignment is causal: output for pixel x reduces pixels max(0,x-WIN+1)..x of the same line. Downstream compensates the (WIN-1)/2 centre offset. No cross-line leakage.
- i_line_start with i_data_valid=0 is ignored.
- Back-to-back line starts (a 1-pixel line) are legal: each one clears the window.
- Reset mid-line discards all state. The first output after reset must come from a pixel carrying i_line_start; behaviour for a pixel without it is the same as a line start with the mode defaulted to 0.
- No backpressure; the block accepts one pixel per cycle.
- Widths: pure compare/select, no arithmetic growth.
- Reduction trees are combinational within a stage. For CHANNELS≤8 and WIN≤15 they must close at the pixel clock target.

Test Plan:
- WIN=1, mode 0, pixels (R,G,B)=(90,40,70),(10,200,5),(255,255,255) back-to-back -> o_dark 40,5,255 three cycles after each input; o_data_valid high for 3 cycles.
- WIN=3, mode 0, line start then channel-mins 50,20,80,90,10 -> o_dark 50,20,20,20,10; o_line_start only on the first output.
- WIN=3, continue with new line start carrying mins 200,100 -> 200,100 (no leakage of 10 from the previous line).
- WIN=3, line start with i_mode=1, pixels (10,200,30),(5,6,7),(1,2,3),(0,0,9); toggle i_mode to 0 on pixel 2 -> o_dark 200,200,200,9 (mode change ignored mid-line).
- WIN=3, mode 0, mins 30,_,_,60,5 where _ = i_data_valid low -> outputs 30,30,5 on the three valid output cycles; o_dark=0 on the gap cycles.
- Assert reset_n low mid-line with pipeline full -> outputs immediately 0/0/0; after release, a line start with min 77 -> o_dark 77, unaffected by pre-reset contents.
